// File: rtl/rgbled_chain_if.sv
// rgbled_chain_if: pixel write port plus frame start/busy/done handshake
interface rgbled_chain_if #(
    parameter int NUM_LEDS = 8,
    parameter int CH = 3,
    parameter int COLOR_W = 8
);
    localparam int AW = NUM_LEDS > 1 ? $clog2(NUM_LEDS) : 1;
    logic wr_en;
    logic [AW-1:0] wr_addr;
    logic [CH*COLOR_W-1:0] wr_data;
    logic start;
    logic busy;
    logic done;
    modport master(output wr_en, wr_addr, wr_data, start, input busy, done);
    modport slave(input wr_en, wr_addr, wr_data, start, output busy, done);
endinterface

// File: rtl/rgbled_chain.sv
// rgbled_chain: WS2812-style one-wire NRZ driver streaming a NUM_LEDS frame buffer
module rgbled_chain #(
    parameter int NUM_LEDS = 8,
    parameter int CH = 3,
    parameter int COLOR_W = 8,
    parameter int T_BIT = 25,
    parameter int T0H = 8,
    parameter int T1H = 16,
    parameter int T_RST = 1000
) (
    input  logic           clk,
    input  logic           reset,
    rgbled_chain_if.slave  bus,
    output logic           led_out
);
    localparam int PW = CH * COLOR_W;
    localparam int AW = NUM_LEDS > 1 ? $clog2(NUM_LEDS) : 1;
    localparam int CW = $clog2(T_BIT);
    localparam int BW = PW > 1 ? $clog2(PW) : 1;
    localparam int LW = $clog2(T_RST + 1);
    typedef enum logic [1:0] {IDLE, HIGH, LOW, LATCH} state_t;
    state_t state;
    logic [PW-1:0] frame [NUM_LEDS];
    logic [PW-1:0] shreg;
    logic [CW-1:0] cnt;
    logic [BW-1:0] bit_idx;
    logic [AW-1:0] px;
    logic [LW-1:0] lcnt;
    logic busy;
    logic done;
    logic wr_ok;
    logic [PW-1:0] first_px;
    logic [CW-1:0] t_high;
    // Pixels are stored already in wire order (G,R,B[,W]) so the shifter just emits MSB first
    function automatic logic [PW-1:0] to_wire(input logic [PW-1:0] d);
        return {d[PW-COLOR_W-1 -: COLOR_W], d[PW-1 -: COLOR_W], d[PW-2*COLOR_W-1:0]};
    endfunction
    assign bus.busy = busy;
    assign bus.done = done;
    always_comb begin
        wr_ok = bus.wr_en && !busy && int'(bus.wr_addr) < NUM_LEDS;
        first_px = (wr_ok && bus.wr_addr == '0) ? to_wire(bus.wr_data) : frame[0];
        t_high = shreg[PW-1] ? CW'(T1H - 1) : CW'(T0H - 1);
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            busy <= 1'b0;
            done <= 1'b0;
            led_out <= 1'b0;
            shreg <= '0;
            cnt <= '0;
            bit_idx <= '0;
            px <= '0;
            lcnt <= '0;
            for (int i = 0; i < NUM_LEDS; i++) frame[i] <= '0;
        end else begin
            if (wr_ok) frame[bus.wr_addr] <= to_wire(bus.wr_data);
            case (state)
                IDLE: if (bus.start) begin
                    state <= HIGH;
                    busy <= 1'b1;
                    led_out <= 1'b1;
                    shreg <= first_px;
                    cnt <= '0;
                    bit_idx <= '0;
                    px <= '0;
                end
                HIGH: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == t_high) begin
                        state <= LOW;
                        led_out <= 1'b0;
                    end
                end
                LOW: if (cnt == CW'(T_BIT - 1)) begin
                    cnt <= '0;
                    if (bit_idx != BW'(PW - 1)) begin
                        state <= HIGH;
                        led_out <= 1'b1;
                        shreg <= shreg << 1;
                        bit_idx <= bit_idx + 1'b1;
                    end else if (px != AW'(NUM_LEDS - 1)) begin
                        // Next pixel loads on the last low cycle so the stream has no gap
                        state <= HIGH;
                        led_out <= 1'b1;
                        shreg <= frame[px + 1'b1];
                        bit_idx <= '0;
                        px <= px + 1'b1;
                    end else begin
                        state <= LATCH;
                        lcnt <= '0;
                    end
                end else cnt <= cnt + 1'b1;
                LATCH: begin
                    lcnt <= lcnt + 1'b1;
                    if (lcnt == LW'(T_RST - 1)) begin
                        done <= 1'b1;
                        busy <= 1'b0;
                    end
                    if (lcnt == LW'(T_RST)) begin
                        state <= IDLE;
                        done <= 1'b0;
                        lcnt <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
